cdb_broadcast_arbiter: RTL and testbench

Parametrised common-data-bus (CDB) arbiter and broadcast stage for the out-of-order core. It collects result requests from `PRODUCERS` execution units and selects one per cycle, by fixed priority or round-robin. The winner's tag and data are broadcast to every CDB consumer (register file controller, reservation stations). A saturating contention counter is included for performance bring-up.

---
 rtl/cdb_pkg.sv | 13 +
 rtl/cdb_rr_select.sv | 29 ++
 rtl/cdb_broadcast_arbiter.sv | 105 ++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared constants and helpers for the CDB arbiter/broadcast slice.
package cdb_pkg;

  localparam int ARB_FIXED          = 0;
  localparam int ARB_RR             = 1;
  localparam int CDB_DATA_WIDTH_DEF = 4;
  localparam int CDB_TAG_WIDTH_DEF  = 4;

  function automatic int rr_ptr_next(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage

// File: rtl/cdb_rr_select.sv
// Combinational one-hot selector: fixed priority from index 0, or rotated
// priority starting at rr_ptr using a doubled request vector.
module cdb_rr_select
  import cdb_pkg::*;
#(
  parameter int PRODUCERS = 4,
  parameter int PTR_W     = 2,
  parameter int ARB_MODE  = ARB_FIXED
) (
  input  logic [PRODUCERS-1:0] req,
  input  logic [PTR_W-1:0]     rr_ptr,
  output logic [PRODUCERS-1:0] grant
);

  logic [PTR_W-1:0]       start;
  logic [PRODUCERS-1:0]   rot;
  logic [PRODUCERS-1:0]   rot_gnt;
  logic [2*PRODUCERS-1:0] gnt_dbl;

  always_comb begin
    start   = (ARB_MODE == ARB_RR) ? rr_ptr : '0;
    // Rotate so the pointer lands at bit 0, take the lowest set bit, rotate back.
    rot     = PRODUCERS'({req, req} >> start);
    rot_gnt = rot & (~rot + PRODUCERS'(1));
    gnt_dbl = {{PRODUCERS{1'b0}}, rot_gnt} << start;
    grant   = gnt_dbl[PRODUCERS-1:0] | gnt_dbl[2*PRODUCERS-1:PRODUCERS];
  end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// CDB arbiter + broadcast stage. Define CDB_OUT_REG_EN to register the
// broadcast outputs (one cycle latency); grant is always combinational.
module cdb_broadcast_arbiter
  import cdb_pkg::*;
#(
  parameter int PRODUCERS       = 4,
  parameter int DATA_WIDTH      = CDB_DATA_WIDTH_DEF,
  parameter int CDB_TAG_WIDTH   = CDB_TAG_WIDTH_DEF,
  parameter int ARB_MODE        = ARB_FIXED,
  parameter int STALL_CNT_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PRODUCERS-1:0]               req,
  input  logic [PRODUCERS*CDB_TAG_WIDTH-1:0] req_tag,
  input  logic [PRODUCERS*DATA_WIDTH-1:0]    req_data,
  output logic [PRODUCERS-1:0]               grant,
  output logic                               cdb_valid,
  output logic [CDB_TAG_WIDTH-1:0]           cdb_tag,
  output logic [DATA_WIDTH-1:0]              cdb_data,
  output logic [STALL_CNT_WIDTH-1:0]         stall_count
);

  localparam int PTR_W = (PRODUCERS > 1) ? $clog2(PRODUCERS) : 1;

  logic [PTR_W-1:0]         rr_ptr;
  logic [PRODUCERS-1:0]     sel_grant;
  logic                     any_grant;
  logic                     contention;
  logic [PTR_W-1:0]         win_idx;
  logic [CDB_TAG_WIDTH-1:0] mux_tag;
  logic [DATA_WIDTH-1:0]    mux_data;

  cdb_rr_select #(
    .PRODUCERS (PRODUCERS),
    .PTR_W     (PTR_W),
    .ARB_MODE  (ARB_MODE)
  ) u_select (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (sel_grant)
  );

  assign grant      = rst_n ? sel_grant : '0;
  assign any_grant  = |grant;
  // Two or more requesters iff clearing the lowest set bit leaves something.
  assign contention = |(req & (req - PRODUCERS'(1)));

  always_comb begin
    win_idx  = '0;
    mux_tag  = '0;
    mux_data = '0;
    for (int i = 0; i < PRODUCERS; i++) begin
      if (grant[i]) begin
        win_idx  = PTR_W'(i);
        mux_tag  = req_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        mux_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((ARB_MODE == ARB_RR) && any_grant) begin
      rr_ptr <= PTR_W'(rr_ptr_next(int'(win_idx), PRODUCERS));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (contention && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end

`ifdef CDB_OUT_REG_EN
  logic                     vld_p1;
  logic [CDB_TAG_WIDTH-1:0] tag_p1;
  logic [DATA_WIDTH-1:0]    data_p1;

  // p0 -> p1: mux output already zero when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      tag_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= any_grant;
      tag_p1  <= mux_tag;
      data_p1 <= mux_data;
    end
  end

  assign cdb_valid = vld_p1;
  assign cdb_tag   = tag_p1;
  assign cdb_data  = data_p1;
`else
  assign cdb_valid = any_grant;
  assign cdb_tag   = mux_tag;
  assign cdb_data  = mux_data;
`endif

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Directed bench for cdb_broadcast_arbiter: fixed-priority table, round-robin
// sequence with mid-operation reset, and a 2-bit counter saturation run.
module tb_cdb_broadcast_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_f, req_r, req_s;
  logic [15:0] req_tag, req_data;

  logic [3:0] grant_f, grant_r, grant_s;
  logic       valid_f, valid_r, valid_s;
  logic [3:0] tag_f, tag_r, tag_s;
  logic [3:0] data_f, data_r, data_s;
  logic [7:0] stall_f, stall_r;
  logic [1:0] stall_s;

  cdb_broadcast_arbiter #(.PRODUCERS(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4),
                          .ARB_MODE(0), .STALL_CNT_WIDTH(8)) dut_f (
    .clk(clk), .rst_n(rst_n), .req(req_f), .req_tag(req_tag), .req_data(req_data),
    .grant(grant_f), .cdb_valid(valid_f), .cdb_tag(tag_f), .cdb_data(data_f),
    .stall_count(stall_f));

  cdb_broadcast_arbiter #(.PRODUCERS(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4),
                          .ARB_MODE(1), .STALL_CNT_WIDTH(8)) dut_r (
    .clk(clk), .rst_n(rst_n), .req(req_r), .req_tag(req_tag), .req_data(req_data),
    .grant(grant_r), .cdb_valid(valid_r), .cdb_tag(tag_r), .cdb_data(data_r),
    .stall_count(stall_r));

  cdb_broadcast_arbiter #(.PRODUCERS(4), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4),
                          .ARB_MODE(0), .STALL_CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .req(req_s), .req_tag(req_tag), .req_data(req_data),
    .grant(grant_s), .cdb_valid(valid_s), .cdb_tag(tag_s), .cdb_data(data_s),
    .stall_count(stall_s));

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bcast_r(input string name, input logic v, input logic [3:0] t,
                             input logic [3:0] d);
    chk({name, " valid"}, 32'(valid_r), 32'(v));
    chk({name, " tag"},   32'(tag_r),   32'(t));
    chk({name, " data"},  32'(data_r),  32'(d));
  endtask

  typedef struct packed {
    logic [3:0]  req;
    logic [15:0] tag;
    logic [15:0] data;
    logic [3:0]  grant;
    logic        valid;
    logic [3:0]  ctag;
    logic [3:0]  cdata;
    logic [7:0]  stall;
  } vec_t;

  vec_t vt [11];

  // Round-robin grant order with 4'b1111 held: 0,1,2,3,0 then 1.
  logic [3:0] rr_exp [6];

  initial begin
    vt[0]  = '{4'b0000, 16'h3215, 16'hBEEF, 4'b0000, 1'b0, 4'h0, 4'h0, 8'd0};
    vt[1]  = '{4'b1010, 16'h3215, 16'hBEEF, 4'b0010, 1'b1, 4'h1, 4'hE, 8'd1};
    vt[2]  = '{4'b1000, 16'h3215, 16'hBEEF, 4'b1000, 1'b1, 4'h3, 4'hB, 8'd1};
    vt[3]  = '{4'b1111, 16'h9ABC, 16'h1234, 4'b0001, 1'b1, 4'hC, 4'h4, 8'd2};
    vt[4]  = '{4'b0100, 16'h9ABC, 16'h1234, 4'b0100, 1'b1, 4'hA, 4'h2, 8'd2};
    vt[5]  = '{4'b0110, 16'h9ABC, 16'h1234, 4'b0010, 1'b1, 4'hB, 4'h3, 8'd3};
    vt[6]  = '{4'b1100, 16'h7654, 16'h5A5A, 4'b0100, 1'b1, 4'h6, 4'hA, 8'd4};
    vt[7]  = '{4'b0000, 16'h7654, 16'h5A5A, 4'b0000, 1'b0, 4'h0, 4'h0, 8'd4};
    vt[8]  = '{4'b1000, 16'hF000, 16'h0000, 4'b1000, 1'b1, 4'hF, 4'h0, 8'd4};
    vt[9]  = '{4'b0100, 16'h0500, 16'h0A00, 4'b0100, 1'b1, 4'h5, 4'hA, 8'd4};
    vt[10] = '{4'b0000, 16'h0500, 16'h0A00, 4'b0000, 1'b0, 4'h0, 4'h0, 8'd4};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset with requests present: grant must stay low.
    rst_n = 1'b0; req_f = 4'b1111; req_r = 4'b1111; req_s = 4'b0011;
    req_tag = 16'h3215; req_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset grant_f", 32'(grant_f), 32'd0);
    chk("reset grant_r", 32'(grant_r), 32'd0);
    chk("reset valid_f", 32'(valid_f), 32'd0);
    chk("reset tag_f",   32'(tag_f),   32'd0);
    chk("reset stall_f", 32'(stall_f), 32'd0);
    rst_n = 1'b1; req_r = 4'b0000; req_s = 4'b0000;

    // Fixed-priority table.
    for (int i = 0; i < 11; i++) begin
      req_f = vt[i].req; req_tag = vt[i].tag; req_data = vt[i].data;
      #2;
      chk($sformatf("vec%0d grant", i), 32'(grant_f), 32'(vt[i].grant));
`ifndef CDB_OUT_REG_EN
      chk($sformatf("vec%0d valid", i), 32'(valid_f), 32'(vt[i].valid));
      chk($sformatf("vec%0d tag", i),   32'(tag_f),   32'(vt[i].ctag));
      chk($sformatf("vec%0d data", i),  32'(data_f),  32'(vt[i].cdata));
`endif
      @(posedge clk); #1;
`ifdef CDB_OUT_REG_EN
      chk($sformatf("vec%0d valid", i), 32'(valid_f), 32'(vt[i].valid));
      chk($sformatf("vec%0d tag", i),   32'(tag_f),   32'(vt[i].ctag));
      chk($sformatf("vec%0d data", i),  32'(data_f),  32'(vt[i].cdata));
`endif
      chk($sformatf("vec%0d stall", i), 32'(stall_f), 32'(vt[i].stall));
    end
    req_f = 4'b0000;

    // Saturation: 2-bit counter under continuous two-way contention.
    chk("sat start", 32'(stall_s), 32'd0);
    req_s = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("sat%0d grant", i), 32'(grant_s), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d count", i), 32'(stall_s), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    req_s = 4'b0000;

    // Round-robin: full request vector rotates and wraps.
    req_tag = 16'h3215; req_data = 16'hBEEF;
    req_r = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("rr%0d grant", i), 32'(grant_r), 32'(rr_exp[i]));
      @(posedge clk); #1;
      chk($sformatf("rr%0d stall", i), 32'(stall_r), 32'(i + 1));
    end

    // Idle cycle: pointer must hold at 2.
    req_r = 4'b0000;
    #2;
    chk("rr idle grant", 32'(grant_r), 32'd0);
`ifndef CDB_OUT_REG_EN
    chk_bcast_r("rr idle", 1'b0, 4'h0, 4'h0);
`endif
    @(posedge clk); #1;
`ifdef CDB_OUT_REG_EN
    chk_bcast_r("rr idle", 1'b0, 4'h0, 4'h0);
`endif
    req_r = 4'b1111;
    #2;
    chk("rr after idle grant", 32'(grant_r), 32'b0100);
    @(posedge clk); #1;

    // Pointer now 3 with requests pending; a one-cycle reset discards it.
    req_r = 4'b1011;
    #2;
    chk("rr ptr3 grant", 32'(grant_r), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk("rr in-reset grant", 32'(grant_r), 32'd0);
    @(posedge clk); #1;
    chk("rr reset stall", 32'(stall_r), 32'd0);
    rst_n = 1'b1;
    #2;
    chk("rr post-reset grant", 32'(grant_r), 32'b0001);
    @(posedge clk); #1;

    // Pointer is 1: search 1,2,3 finds producer 3 ahead of producer 0.
    req_r = 4'b1001;
    #2;
    chk("rr ptr1 grant", 32'(grant_r), 32'b1000);
`ifndef CDB_OUT_REG_EN
    chk_bcast_r("rr ptr1", 1'b1, 4'h3, 4'hB);
`endif
    @(posedge clk); #1;
`ifdef CDB_OUT_REG_EN
    chk_bcast_r("rr ptr1", 1'b1, 4'h3, 4'hB);
`endif
    req_r = 4'b0000;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
